gpio_bank: RTL
==============

// Module: gpio_bank
// PURPOSE
//   Parametrised memory-mapped GPIO bank; successor to the single-register output port.
//   Adds per-pin direction, synchronised input sampling, atomic set/clear and per-pin
//   edge interrupts with W1C status. Sits behind the address decoder on the same we/re
//   CPU bus; drives pads/LEDs and raises one level interrupt to the CPU.
// PARAMETERS
//   WIDTH        32  number of GPIO pins, 1..32
//   SYNC_STAGES  2   input synchroniser flops, 2..4
//   OUT_RESET    0   reset value of OUT register, WIDTH bits
// PORTS
//   clk       in   1      single clock; all state on posedge clk
//   reset_n   in   1      asynchronous, active-low reset
//   we        in   1      write enable from address decoder
//   re        in   1      read enable from address decoder
//   addr      in   3      register select (word index)
//   data_in   in   32     write data from CPU
//   data_out  out  32     read data to CPU; 0 when re=0
//   gpio_in   in   WIDTH  asynchronous pad inputs
//   gpio_out  out  WIDTH  pad output values (= OUT)
//   gpio_oe   out  WIDTH  pad output enables (= DIR, 1 = drive)
//   irq       out  1      registered level interrupt
// BEHAVIOUR
//   Map: 0 OUT rw | 1 DIR rw | 2 IN ro | 3 IRQ_EN rw | 4 IRQ_TYPE rw (1=rise, 0=fall)
//        5 IRQ_STAT rw1c | 6 SET wo | 7 CLR wo.
//   Writes take effect at the we-cycle clock edge. Reads are combinational:
//     data_out = re ? reg[addr] zero-extended to 32 : 0. SET/CLR read as 0.
//   data_in[31:WIDTH] ignored on writes.
//   SET: OUT |= data_in. CLR: OUT &= ~data_in.
//   IN = last synchroniser stage; visible SYNC_STAGES cycles after a pad change,
//     regardless of DIR.
//   Edge detect: a 1-cycle-delayed copy of IN. rise = IN & ~prev; fall = ~IN & prev.
//     Pin edge = IRQ_TYPE ? rise : fall.
//   STAT[i] is set on a detected edge, independent of IRQ_EN.
//     Writing 1 to bit i of STAT clears it; writing 0 leaves it unchanged.
//   Same-cycle W1C and new edge on the same bit: the set wins (STAT[i] = 1).
//   irq <= |(STAT & IRQ_EN), registered, so irq lags the STAT change by 1 cycle.
//   Startup guard: an arm counter blocks edge detection for SYNC_STAGES+1 cycles after
//     reset_n deasserts, so pads already high at reset raise no spurious edge.
//     While disarmed, prev tracks IN.
//   Reset (async assert, any time): OUT=OUT_RESET; DIR, IRQ_EN, IRQ_TYPE, STAT,
//     synchroniser, prev, arm counter and irq all 0.
//     gpio_out=OUT_RESET; gpio_oe=0; data_out=0 whenever re=0.
//   we and re may both be high in one cycle: the read returns the pre-write value.
// STRUCTURE
//   gpio_pkg: address constants ADDR_OUT..ADDR_CLR and the bus data width constant (32).
//   Sub-module gpio_sync: WIDTH x SYNC_STAGES synchroniser chain with async reset.
//   All remaining registers, edge logic and the arm counter live in gpio_bank.
// TESTING
//   1. Reset with OUT_RESET=8'hA5 and WIDTH=8 -> gpio_out=A5, gpio_oe=00, irq=0,
//      read addr0 = 0x000000A5.
//   2. Write OUT=0x0F, then SET 0xF0, then CLR 0x03 -> gpio_out=0xFC;
//      reading addr6 and addr7 returns 0.
//   3. Pad 3 goes 0->1 with TYPE[3]=1, EN[3]=1 -> IN[3] high after 2 cycles,
//      STAT[3]=1 on the next edge, irq=1 one cycle later.
//      Write STAT=0x08 -> irq drops one cycle after the clear.
//   4. Pad 0 held high through reset release -> no STAT bit set; a later 1->0 with
//      TYPE[0]=0 sets STAT[0].
//   5. W1C on STAT[2] in the same cycle a new edge on pin 2 is detected -> STAT[2]
//      stays 1. Fall edge with TYPE=1 -> STAT unchanged.
//   6. Assert reset_n low mid-operation with STAT=0xFF and irq=1 -> irq, STAT and DIR
//      go to 0 immediately, without waiting for clk.
//      Read of addr 2 with WIDTH=8 -> bits 31:8 are 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register map and CPU bus width.
package gpio_pkg;

    localparam int BUS_W = 32;

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_TYPE = 3'd4;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd5;
    localparam logic [2:0] ADDR_SET      = 3'd6;
    localparam logic [2:0] ADDR_CLR      = 3'd7;

endpackage

// File: rtl/gpio_bank_if.sv
// CPU-side register bus of the GPIO bank (decoded we/re strobes, word address, data).
interface gpio_bank_if;
    import gpio_pkg::*;

    logic             we;
    logic             re;
    logic [2:0]       addr;
    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] data_out;

    modport master (output we, re, addr, data_in, input data_out);
    modport slave  (input we, re, addr, data_in, output data_out);

endinterface

// File: rtl/gpio_sync.sv
// WIDTH-bit multi-flop synchroniser for asynchronous pad inputs.
module gpio_sync #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR registers, atomic SET/CLR, synchronised inputs
// and per-pin edge interrupts with write-1-to-clear status.
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] irq_en_r;
    logic [WIDTH-1:0] irq_type_r;
    logic [WIDTH-1:0] irq_stat_r;
    logic [WIDTH-1:0] in_p0;
    logic [WIDTH-1:0] in_p1;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] rd_mux;
    logic             unused_data_hi;

    // Bits above WIDTH carry no register state.
    assign wdata          = bus.data_in[WIDTH-1:0];
    assign unused_data_hi = ^bus.data_in;

    // Stage p0: pad inputs after the synchroniser (the IN register).
    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (gpio_in),
        .q       (in_p0)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_r      <= OUT_RESET;
            dir_r      <= '0;
            irq_en_r   <= '0;
            irq_type_r <= '0;
        end else if (bus.we) begin
            case (bus.addr)
                ADDR_OUT:      out_r      <= wdata;
                ADDR_DIR:      dir_r      <= wdata;
                ADDR_IRQ_EN:   irq_en_r   <= wdata;
                ADDR_IRQ_TYPE: irq_type_r <= wdata;
                ADDR_SET:      out_r      <= out_r | wdata;
                ADDR_CLR:      out_r      <= out_r & ~wdata;
                default:       ;
            endcase
        end
    end

    // Edge detection stays masked until the synchroniser has flushed its reset zeros,
    // so a pad already high at reset release is not mistaken for a rising edge.
    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    // Stage p1: one-cycle-delayed IN used as the edge reference.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_p1 <= '0;
        end else begin
            in_p1 <= in_p0;
        end
    end

    assign rise     = in_p0 & ~in_p1;
    assign fall     = ~in_p0 & in_p1;
    assign edge_hit = armed ? ((irq_type_r & rise) | (~irq_type_r & fall)) : '0;
    assign w1c_mask = (bus.we && bus.addr == ADDR_IRQ_STAT) ? wdata : '0;

    // A new edge overrides a simultaneous clear of the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_stat_r <= '0;
            irq        <= 1'b0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~w1c_mask) | edge_hit;
            irq        <= |(irq_stat_r & irq_en_r);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            ADDR_OUT:      rd_mux = out_r;
            ADDR_DIR:      rd_mux = dir_r;
            ADDR_IN:       rd_mux = in_p0;
            ADDR_IRQ_EN:   rd_mux = irq_en_r;
            ADDR_IRQ_TYPE: rd_mux = irq_type_r;
            ADDR_IRQ_STAT: rd_mux = irq_stat_r;
            default:       rd_mux = '0;
        endcase
    end

    assign bus.data_out = bus.re ? BUS_W'(rd_mux) : '0;
    assign gpio_out     = out_r;
    assign gpio_oe      = dir_r;

endmodule
